// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//  - Size codes carried on req_size.
//  - FSM state encoding.
//  - Latched request record.
//  - Request legality check: misalignment, out-of-range address, illegal size.
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  typedef struct packed {
    logic        store;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } lsu_req_t;

  // Returns 1 when the request must be answered with resp_err and no memory access.
  function automatic logic req_is_bad(input logic        store,
                                      input logic [2:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] limit);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B, SZ_BU:  bad = 1'b0;
      SZ_H, SZ_HU:  bad = addr[0];
      SZ_W:         bad = |addr[1:0];
      default:      bad = 1'b1;
    endcase
    // Unsigned variants only make sense for loads.
    if (store && (size == SZ_BU || size == SZ_HU)) bad = 1'b1;
    if (addr >= limit) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (purely combinational).
//  size_i   : request size code
//  off_i    : byte offset within the word (addr[1:0])
//  rdata_i  : word read from memory
//  wdata_i  : store data from the core (low 8/16/32 bits used)
//  load_o   : extracted and sign/zero-extended load result
//  merge_o  : rdata_i with only the addressed lane replaced by store data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  byte_en;
  logic [31:0] lane_data;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SZ_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   load_o = {24'h0, byte_sel};
      SZ_H:    load_o = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   load_o = {16'h0, half_sel};
      default: load_o = rdata_i;
    endcase
  end

  // Store data is replicated across all lanes; the byte enables pick which lanes land.
  always_comb begin
    case (size_i)
      SZ_B, SZ_BU: begin
        byte_en   = 4'b0001 << off_i;
        lane_data = {4{wdata_i[7:0]}};
      end
      SZ_H, SZ_HU: begin
        byte_en   = off_i[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_i[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        lane_data = wdata_i;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merge_o[gi*8 +: 8] = byte_en[gi] ? lane_data[gi*8 +: 8] : rdata_i[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-indexed data-memory port.
// Accepts one request at a time over req_valid/req_ready, performs the access
// (read-modify-write for sub-word stores) and returns one response held until
// resp_ready.
//  clk, rst_n                  : clock, synchronous active-low reset
//  req_valid/ready/store/size/addr/wdata : request channel from the core
//  resp_valid/ready/rdata/err  : response channel to the core
//  mem_addr/wdata/read/write   : memory port (combinational read, write on clock edge)
//  mem_rdata                   : memory read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_size,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        req_bad;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic [31:0] wr_word;
  logic        unused_addr_hi;

  assign req_bad = req_is_bad(req_store, req_size, req_addr, ADDR_LIMIT);
  assign accept  = rst_n && (state_q == ST_IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{store: req_store, size: req_size, addr: req_addr,
                   wdata: req_wdata, err: req_bad};
      end
      if (state_q == ST_RD) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad)                    state_d = ST_RESP;
          else if (!req_store)            state_d = ST_RD;
          else if (req_size == SZ_W)      state_d = ST_WR;
          else                            state_d = ST_RD;  // sub-word store reads first
        end
      end
      ST_RD:   state_d = req_q.store ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .size_i  (req_q.size),
    .off_i   (req_q.addr[1:0]),
    .rdata_i (rdata_q),
    .wdata_i (req_q.wdata),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

  assign wr_word = (req_q.size == SZ_W) ? req_q.wdata : merge_data;

  // Every output is qualified by rst_n so a reset cycle shows all-zero outputs
  // and, in particular, a reset coinciding with WR commits nothing.
  always_comb begin
    req_ready  = rst_n && (state_q == ST_IDLE);
    mem_read   = rst_n && (state_q == ST_RD);
    mem_write  = rst_n && (state_q == ST_WR);
    mem_addr   = (mem_read || mem_write) ? req_q.addr[IDX_W+1:2] : '0;
    mem_wdata  = mem_write ? wr_word : '0;
    resp_valid = rst_n && (state_q == ST_RESP);
    resp_err   = resp_valid && req_q.err;
    resp_rdata = (resp_valid && !req_q.err && !req_q.store) ? load_data : '0;
  end

  assign unused_addr_hi = ^req_q.addr[31:IDX_W+2];

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_size = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(64), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int w);
    if (w == 3) return 32'h8899_AABB;
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory attached to the port: combinational read, write on the clock edge.
  logic [31:0] mem [64];
  bit          mem_init = 1'b0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int w = 0; w < 64; w++) mem[w] <= init_word(w);
      mem_init <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model: byte-addressed memory image plus legality rules.
  logic [7:0] ref_b [256];

  function automatic int sz_width(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_err(input bit st, input logic [2:0] sz, input logic [31:0] a);
    int w;
    w = sz_width(sz);
    if (w == 0) return 1'b1;
    if (st && sz[2]) return 1'b1;
    if (a >= 32'd256) return 1'b1;
    return (int'(a[7:0]) % w) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a);
    int w;
    logic [31:0] v;
    w = sz_width(sz);
    v = '0;
    for (int i = 0; i < w; i++) v = v | (32'(ref_b[int'(a[7:0]) + i]) << (8 * i));
    if (!sz[2] && w < 4 && v[8*w-1]) v = v | (32'hFFFF_FFFF << (8 * w));
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[7:0]) & ~3;
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  task automatic ref_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int w;
    w = sz_width(sz);
    for (int i = 0; i < w; i++) ref_b[int'(a[7:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Cycle-level invariants on the memory port.
  always @(negedge clk) begin
    chk1("rd_wr_exclusive", mem_read && mem_write, 1'b0);
    if (!mem_read && !mem_write) begin
      chk("idle_mem_addr", 32'(mem_addr), 32'h0);
      chk("idle_mem_wdata", mem_wdata, 32'h0);
    end
  end

  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] last_wword;
  bit          p_en = 1'b0;
  bit          p_st;
  logic [2:0]  p_sz;
  logic [31:0] p_a;
  logic [31:0] p_wd;

  // One transaction: present, accept, follow the access cycle by cycle against
  // the model's timeline, hold the response for `hold` cycles, then hand it off.
  task automatic do_req(input bit st, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    bit          e_err;
    logic [31:0] e_rdata, e_wword;
    int          lat, rd_cyc, wr_cyc, n;
    e_err   = ref_err(st, sz, a);
    e_rdata = '0;
    e_wword = '0;
    if (!e_err) begin
      if (st) begin
        ref_store(sz, a, wd);
        e_wword = ref_word(a);
      end else begin
        e_rdata = ref_load(sz, a);
      end
    end
    if (e_err)           begin lat = 1; rd_cyc = 0; wr_cyc = 0; end
    else if (!st)        begin lat = 2; rd_cyc = 1; wr_cyc = 0; end
    else if (sz == SZ_W) begin lat = 2; rd_cyc = 0; wr_cyc = 1; end
    else                 begin lat = 3; rd_cyc = 1; wr_cyc = 2; end

    @(negedge clk);
    chk1("ready_when_idle", req_ready, 1'b1);
    chk1("no_resp_when_idle", resp_valid, 1'b0);
    req_valid = 1'b1; req_store = st; req_size = sz; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      chk1("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
    req_store = 1'($urandom);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk1("mem_read_timing", mem_read, 1'(k == rd_cyc));
      chk1("mem_write_timing", mem_write, 1'(k == wr_cyc));
      chk1("resp_valid_timing", resp_valid, 1'(k == lat));
      chk1("busy_not_ready", req_ready, 1'b0);
      if (k == rd_cyc || k == wr_cyc) chk("mem_addr", 32'(mem_addr), 32'(a[7:2]));
      if (k == wr_cyc) begin
        chk("mem_wdata", mem_wdata, e_wword);
        last_wword = mem_wdata;
      end
    end
    chk("resp_rdata", resp_rdata, e_rdata);
    chk1("resp_err", resp_err, e_err);
    last_rdata = resp_rdata;
    last_err   = resp_err;
    $display("txn st=%0d sz=%0d addr=%h wdata=%h -> rdata=%h err=%0d", st, sz, a, wd, resp_rdata, resp_err);

    if (p_en) begin
      req_valid = 1'b1; req_store = p_st; req_size = p_sz; req_addr = p_a; req_wdata = p_wd;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk1("hold_valid", resp_valid, 1'b1);
      chk("hold_rdata", resp_rdata, last_rdata);
      chk1("hold_err", resp_err, last_err);
      chk1("hold_not_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iw;
    bit          st;
    logic [2:0]  sz;
    logic [31:0] a;
    int          r, w;
    logic [2:0]  sizes [13];
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    for (int wi = 0; wi < 64; wi++) begin
      iw = init_word(wi);
      for (int i = 0; i < 4; i++) ref_b[4*wi + i] = iw[8*i +: 8];
    end

    // Reset
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk1("rst_resp_err", resp_err, 1'b0);
      chk1("rst_mem_read", mem_read, 1'b0);
      chk1("rst_mem_write", mem_write, 1'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases with hand-computed results
    do_req(1'b0, SZ_W, 32'h0C, 32'h0, 0);
    chk("lw_0c_literal", last_rdata, 32'h8899_AABB);
    do_req(1'b0, SZ_B, 32'h0D, 32'h0, 1);
    chk("lb_0d_literal", last_rdata, 32'hFFFF_FFAA);
    do_req(1'b0, SZ_BU, 32'h0D, 32'h0, 0);
    chk("lbu_0d_literal", last_rdata, 32'h0000_00AA);
    do_req(1'b0, SZ_HU, 32'h0E, 32'h0, 0);
    chk("lhu_0e_literal", last_rdata, 32'h0000_8899);
    do_req(1'b1, SZ_B, 32'h0E, 32'h0000_0055, 0);
    chk("sb_merge_literal", last_wword, 32'h8855_AABB);
    do_req(1'b0, SZ_W, 32'h0C, 32'h0, 0);
    chk("sb_readback_literal", last_rdata, 32'h8855_AABB);
    do_req(1'b0, SZ_W, 32'h0E, 32'h0, 0);
    chk1("lw_misaligned_literal", last_err, 1'b1);
    do_req(1'b1, SZ_W, 32'h100, 32'hDEAD_BEEF, 0);
    chk1("sw_out_of_range_literal", last_err, 1'b1);
    do_req(1'b1, SZ_BU, 32'h10, 32'h0000_0077, 0);
    chk1("sb_bu_illegal_literal", last_err, 1'b1);

    // Long response stall with the next request already waiting
    p_en = 1'b1; p_st = 1'b0; p_sz = SZ_H; p_a = 32'h0E; p_wd = 32'h0;
    do_req(1'b0, SZ_W, 32'h0C, 32'h0, 5);
    p_en = 1'b0;
    do_req(p_st, p_sz, p_a, p_wd, 0);
    chk("lh_after_stall_literal", last_rdata, 32'hFFFF_8855);

    // Reset during the WR cycle of a word store
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = SZ_W; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk1("wr_rst_mem_write", mem_write, 1'b0);
    chk1("wr_rst_mem_read", mem_read, 1'b0);
    chk1("wr_rst_req_ready", req_ready, 1'b0);
    chk1("wr_rst_resp_valid", resp_valid, 1'b0);
    chk("wr_rst_resp_rdata", resp_rdata, 32'h0);
    chk1("wr_rst_resp_err", resp_err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("ready_after_release", req_ready, 1'b1);
    chk("wr_rst_no_commit", mem[8], ref_word(32'h20));
    $display("txn reset-during-WR addr=00000020 -> mem word=%h", mem[8]);
    do_req(1'b0, SZ_W, 32'h20, 32'h0, 0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      st = 1'($urandom_range(0, 1));
      sz = sizes[$urandom_range(0, 12)];
      r  = $urandom_range(0, 9);
      if (r == 0) begin
        a = 32'(256 + $urandom_range(0, 1023));
      end else begin
        a = 32'($urandom_range(0, 255));
        w = sz_width(sz);
        if (r < 7 && w != 0) a = a & ~(32'(w) - 32'd1);
      end
      do_req(st, sz, a, $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
